// File: rtl/cc_banks_ctrl.sv
// cc_banks_ctrl: banked single-port word arrays with byte-masked writes, zero-fill init and an in-order read-response FIFO.
// Define CC_BANKS_OUTREG_EN to add an output pipeline register (L=2, 3-entry FIFO, credit limit 3).
module cc_banks_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int NBANKS = 4,
  localparam int BANK_W = $clog2(NBANKS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W+BANK_W-1:0] req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  input  logic [DATA_W/8-1:0]      req_wmask,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_W-1:0]        resp_rdata,
  output logic                     init_done
);
`ifdef CC_BANKS_OUTREG_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] LIM = 2'(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [ADDR_W-1:0] row_cnt;
  logic [DATA_W-1:0] mem [NBANKS][2**ADDR_W];
  logic [DATA_W-1:0] q [DEPTH];
  logic [1:0] cnt, credit;
  logic [IDX_W-1:0] idx;
  logic [BANK_W-1:0] bank;
  logic [ADDR_W-1:0] row;
  logic acc, acc_rd, pop, push;
  logic [DATA_W-1:0] rd_word, push_data;
  assign bank = req_addr[BANK_W-1:0];
  assign row = req_addr[ADDR_W+BANK_W-1:BANK_W];
  assign init_done = state == RUN;
  assign resp_valid = cnt != 2'd0;
  assign resp_rdata = resp_valid ? q[0] : '0;
  assign pop = resp_valid & resp_ready;
  // a pop in the same cycle frees the slot the new read would take
  assign req_ready = ~reset & init_done & ((credit < LIM) | pop);
  assign acc = req_valid & req_ready;
  assign acc_rd = acc & ~req_write;
  assign rd_word = mem[bank][row];
  assign idx = IDX_W'(cnt - 2'(pop));
`ifdef CC_BANKS_OUTREG_EN
  logic pipe_v;
  logic [DATA_W-1:0] pipe_d;
  always_ff @(posedge clock) begin
    pipe_v <= reset ? 1'b0 : acc_rd;
    pipe_d <= rd_word;
  end
  assign push = pipe_v;
  assign push_data = pipe_d;
  assign credit = cnt + 2'(pipe_v);
`else
  assign push = acc_rd;
  assign push_data = rd_word;
  assign credit = cnt;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      row_cnt <= '0;
    end else if (state == INIT) begin
      row_cnt <= row_cnt + 1'b1;
      if (&row_cnt) state <= RUN;
    end
  end
  // array contents are never reset; INIT is the only thing that zeroes them
  always_ff @(posedge clock) begin
    if (state == INIT) begin
      for (int b = 0; b < NBANKS; b++) mem[b][row_cnt] <= '0;
    end else if (acc & req_write) begin
      for (int i = 0; i < DATA_W/8; i++)
        if (req_wmask[i]) mem[bank][row][i*8 +: 8] <= req_wdata[i*8 +: 8];
    end
  end
  always_ff @(posedge clock) begin
    cnt <= reset ? 2'd0 : cnt + 2'(push) - 2'(pop);
    if (pop) for (int i = 0; i < DEPTH-1; i++) q[i] <= q[i+1];
    if (push) q[idx] <= push_data;
  end
endmodule

// File: tb/tb_cc_banks_ctrl.sv
// tb_cc_banks_ctrl: random + directed stimulus, flat-memory reference model and response scoreboard.
module tb_cc_banks_ctrl;
`ifdef CC_BANKS_OUTREG_EN
  localparam int L = 2, LIM = 3;
`else
  localparam int L = 1, LIM = 2;
`endif
  logic clock = 0, reset = 1, req_valid = 0, req_write = 0, resp_ready = 0;
  logic [4:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0] req_wmask = '0;
  logic req_ready, resp_valid, init_done;
  logic [63:0] resp_rdata;
  cc_banks_ctrl #(.ADDR_W(4), .DATA_W(64), .NBANKS(2)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .init_done(init_done));
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc++;
  logic [63:0] model [32];
  logic [63:0] exp_q [$];
  int errors = 0, checks = 0, n_resp = 0, last_cyc = 0, acc_cyc = 0;
  logic [63:0] last_data = '0;
  bit rand_rdy = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clock) begin
    if (rand_rdy) resp_ready = 1'($urandom_range(0, 1));
    #2;
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
      else chk("resp_data", resp_rdata, exp_q.pop_front());
      last_data = resp_rdata;
      last_cyc = cyc;
      n_resp++;
    end
  end
  task automatic issue(bit w, logic [4:0] a, logic [63:0] d, logic [7:0] m, output bit acc);
    @(negedge clock);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    acc = req_ready;
    if (acc) begin
      if (w) begin
        for (int i = 0; i < 8; i++) if (m[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
      end else begin
        exp_q.push_back(model[a]);
        acc_cyc = cyc;
      end
    end
  endtask
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clock);
      req_valid = 0;
    end
  endtask
  task automatic send(bit w, logic [4:0] a, logic [63:0] d, logic [7:0] m);
    bit acc = 0;
    for (int k = 0; k < 50 && !acc; k++) issue(w, a, d, m, acc);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask
  task automatic wait_resp(int target);
    for (int k = 0; k < 50 && n_resp < target; k++) idle(1);
    chk("resp_timeout", 64'(n_resp >= target), 64'd1);
  endtask
  task automatic do_reset(bit count_init);
    int n = 0;
    @(negedge clock);
    req_valid = 0; resp_ready = 0; reset = 1;
    #1 chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(negedge clock);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    reset = 0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) model[i] = '0;
    if (count_init) begin
      #1;
      while (!init_done && n < 100) begin
        if (req_ready) chk("ready_during_init", 64'd1, 64'd0);
        n++;
        @(negedge clock);
        #1;
      end
      chk("init_cycles", 64'(n), 64'd16);
      chk("ready_after_init", 64'(req_ready), 64'd1);
    end
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit acc;
    int nacc;
    logic [63:0] held;
    do_reset(1);
    resp_ready = 1;
    send(0, 5'h1F, '0, '0);
    wait_resp(1);
    chk("read_1f_zero", last_data, 64'd0);
    send(1, 5'h03, 64'h1122334455667788, 8'h0F);
    send(0, 5'h03, '0, '0);
    wait_resp(2);
    chk("latency", 64'(last_cyc - acc_cyc), 64'(L));
    chk("masked_data", last_data, 64'h0000000055667788);
    send(1, 5'h03, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    send(0, 5'h03, '0, '0);
    wait_resp(3);
    chk("zero_mask", last_data, 64'h0000000055667788);
    send(1, 5'h02, 64'hAAAA_0000_1111_2222, 8'hFF);
    send(1, 5'h03, 64'hBBBB_3333_4444_5555, 8'hFF);
    send(0, 5'h02, '0, '0);
    send(0, 5'h03, '0, '0);
    wait_resp(5);
    chk("bank1_data", last_data, 64'hBBBB_3333_4444_5555);
    for (int i = 0; i < 4; i++) send(1, 5'(8 + i), 64'(100 + i), 8'hFF);
    idle(1);
    resp_ready = 0;
    nacc = 0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 5'(8 + i), '0, '0, acc);
      nacc += int'(acc);
    end
    idle(1);
    #1;
    chk("stall_accepted", 64'(nacc), 64'(LIM));
    chk("stall_ready_low", 64'(req_ready), 64'd0);
    idle(L);
    held = resp_rdata;
    chk("stall_valid", 64'(resp_valid), 64'd1);
    idle(2);
    chk("stall_hold", resp_rdata, held);
    chk("stall_hold_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) idle(1);
    chk("stall_drain", 64'(exp_q.size()), 64'd0);
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(1'($urandom_range(0, 1)), 5'($urandom), {$urandom, $urandom},
                 ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom), acc);
    end
    idle(1);
    rand_rdy = 0;
    resp_ready = 1;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) idle(1);
    chk("random_drain", 64'(exp_q.size()), 64'd0);
    do_reset(0);
    idle(7);
    #1 chk("mid_init_not_done", 64'(init_done), 64'd0);
    do_reset(1);
    resp_ready = 1;
    send(1, 5'h05, 64'h0123_4567_89AB_CDEF, 8'hFF);
    resp_ready = 0;
    send(0, 5'h05, '0, '0);
    idle(L);
    #1 chk("pending_valid", 64'(resp_valid), 64'd1);
    do_reset(1);
    resp_ready = 1;
    send(0, 5'h05, '0, '0);
    wait_resp(n_resp + 1);
    chk("reinit_zero", last_data, 64'd0);
    idle(3);
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cc_banks_ctrl.md
CC_BANKS_CTRL -- requirements
Module: cc_banks_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: per-bank word-address width.
REQ-002 SHALL have parameter DATA_W, default 64: word width, a multiple of 8.
REQ-003 SHALL have parameter NBANKS, default 4: bank count, a power of 2 and at least 2; BANK_W = log2(NBANKS).
REQ-004 SHALL have port clock, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports req_valid input 1 and req_ready output 1: request handshake.
REQ-007 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr, input, ADDR_W+BANK_W: bank = req_addr[BANK_W-1:0]; row = upper bits.
REQ-009 SHALL have port req_wdata, input, DATA_W: write data.
REQ-010 SHALL have port req_wmask, input, DATA_W/8: byte write enables.
REQ-011 SHALL have ports resp_valid output 1 and resp_ready input 1: read-response handshake.
REQ-012 SHALL have port resp_rdata, output, DATA_W: read data.
REQ-013 SHALL have port init_done, output, 1: 1 once array initialisation completes.

Function
REQ-014 SHALL hold NBANKS single-port arrays of 2^ADDR_W x DATA_W words; each accepted request accesses exactly one bank.
REQ-015 SHALL implement FSM INIT -> RUN; reset enters INIT with row counter 0.
REQ-016 In INIT, SHALL write zero to the current row of every bank in parallel each cycle; after row 2^ADDR_W-1, the next state is RUN; init_done=1 from the first RUN cycle.
REQ-017 SHALL hold req_ready=0 throughout INIT and while reset is asserted.
REQ-018 A request SHALL be accepted only on a cycle with req_valid & req_ready.
REQ-019 Accepted writes SHALL update only bytes with req_wmask[i]=1 and SHALL produce no response; a mask of 0 SHALL leave the word unchanged.
REQ-020 An accepted read SHALL present its data with resp_valid=1 exactly L cycles after acceptance if the response queue is empty and resp_ready=1; L=1 by default.
REQ-021 Responses SHALL be returned in acceptance order and buffered in a 2-entry response FIFO.
REQ-022 SHALL keep a credit count of reads in flight plus FIFO occupancy; in RUN, req_ready = (credit < 2) | ~resp_fifo_would_fill; reads SHALL never be dropped.
REQ-023 Writes SHALL be accepted while reads are blocked only if credit < 2; the FIFO never overflows.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the post-write data.
REQ-025 resp_valid and resp_rdata SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-026 An acceptance and a FIFO pop in the same cycle SHALL leave credit unchanged.

Reset
REQ-027 On reset, SHALL drive req_ready=0, resp_valid=0, resp_rdata=0 and init_done=0, and clear the FIFO, credit and in-flight reads.
REQ-028 Reset asserted during INIT or RUN SHALL discard pending responses and restart INIT at row 0.
REQ-029 Array contents SHALL NOT be reset directly; they are zeroed only by INIT.

Configuration
REQ-030 With CC_BANKS_OUTREG_EN defined, SHALL add one output pipeline register, giving L=2 and credit limit 3 with a 3-entry FIFO.
REQ-031 Without CC_BANKS_OUTREG_EN, SHALL use L=1, credit limit 2 and a 2-entry FIFO.

Verification (bench: ADDR_W=4, NBANKS=2, DATA_W=64)
REQ-032 Release reset -> req_ready=0 for 16 cycles, then init_done=1 and req_ready=1; a read of addr 0x1F returns 0.
REQ-033 Write addr 0x03, data 0x1122334455667788, mask 0x0F, then read addr 0x03 next cycle -> resp_rdata=0x0000000055667788 at L cycles after acceptance.
REQ-034 Hold resp_ready=0 and issue 4 back-to-back reads -> exactly 2 accepted (3 with macro), req_ready=0 afterward; then release resp_ready -> responses arrive in order, none lost.
REQ-035 Write addr 0x02 (bank 0) = A and addr 0x03 (bank 1) = B, then read both -> A then B, confirming no cross-bank aliasing.
REQ-036 Assert reset mid-INIT at row 7, and separately with 1 response pending -> resp_valid=0 next cycle, and INIT reruns a full 16 cycles.
